// File: rtl/blit_address_gen.sv
// Blitter stage 2: turns pixel coordinates into destination/source byte addresses.
// Stage A forms the row products and the clip flag; stage B adds bases and columns.
module blit_address_gen #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        reg_command,
   input  logic [ADDR_W-1:0] reg_dest_base,
   input  logic [15:0]       reg_dest_stride,
   input  logic [ADDR_W-1:0] reg_src_base,
   input  logic [15:0]       reg_src_stride,
   input  logic [15:0]       reg_clip_x1,
   input  logic [15:0]       reg_clip_y1,
   input  logic [15:0]       reg_clip_x2,
   input  logic [15:0]       reg_clip_y2,
   input  logic [15:0]       p1_x,
   input  logic [15:0]       p1_y,
   input  logic [15:0]       p1_src_x,
   input  logic [15:0]       p1_src_y,
   input  logic [2:0]        p1_bit_index,
   input  logic              p1_valid,
   output logic              p2_ready,
   input  logic              p3_ready,
   output logic [ADDR_W-1:0] p2_dest_addr,
   output logic [ADDR_W-1:0] p2_src_addr,
   output logic              p2_src_read,
   output logic [2:0]        p2_bit_index,
   output logic              p2_valid,
   output logic              idle
);

   localparam logic [4:0] BLIT_RECT = 5'd1;
   localparam logic [4:0] BLIT_COPY = 5'd2;
   localparam logic [4:0] BLIT_TEXT = 5'd3;

   logic              aValid_q, aValid_d;
   logic              aInside_q, aInside_d;
   logic [15:0]       aX_q, aX_d;
   logic [15:0]       aSrcX_q, aSrcX_d;
   logic [2:0]        aBit_q, aBit_d;
   logic [31:0]       aYdst_q, aYdst_d;
   logic [31:0]       aYsrc_q, aYsrc_d;

   logic              bValid_q, bValid_d;
   logic              bSrcRead_q, bSrcRead_d;
   logic [ADDR_W-1:0] bDest_q, bDest_d;
   logic [ADDR_W-1:0] bSrc_q, bSrc_d;
   logic [2:0]        bBit_q, bBit_d;

   logic              bAdv;
   logic              aAdv;

   // Stage B may load whenever its slot is free or being drained; A follows B.
   assign bAdv     = !bValid_q || p3_ready;
   assign aAdv     = !aValid_q || bAdv;
   assign p2_ready = aAdv;

   always_comb begin
      aValid_d  = aValid_q;
      aInside_d = aInside_q;
      aX_d      = aX_q;
      aSrcX_d   = aSrcX_q;
      aBit_d    = aBit_q;
      aYdst_d   = aYdst_q;
      aYsrc_d   = aYsrc_q;
      if (aAdv) begin
         aValid_d  = p1_valid;
         aX_d      = p1_x;
         aSrcX_d   = p1_src_x;
         aBit_d    = p1_bit_index;
         aYdst_d   = {16'd0, p1_y} * {16'd0, reg_dest_stride};
         aYsrc_d   = {16'd0, p1_src_y} * {16'd0, reg_src_stride};
         aInside_d = (p1_x >= reg_clip_x1) && (p1_x < reg_clip_x2) &&
                     (p1_y >= reg_clip_y1) && (p1_y < reg_clip_y2);
      end
   end

   // Clipped pixels die here: they occupied A but never set bValid.
   always_comb begin
      bValid_d   = bValid_q;
      bSrcRead_d = bSrcRead_q;
      bDest_d    = bDest_q;
      bSrc_d     = bSrc_q;
      bBit_d     = bBit_q;
      if (bAdv) begin
         bValid_d   = aValid_q && aInside_q;
         bSrcRead_d = (reg_command == BLIT_COPY) || (reg_command == BLIT_TEXT);
         bDest_d    = reg_dest_base + ADDR_W'(aYdst_q) + ADDR_W'(aX_q);
         bSrc_d     = reg_src_base + ADDR_W'(aYsrc_q) + ADDR_W'(aSrcX_q);
         bBit_d     = aBit_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         aValid_q   <= 1'b0;
         aInside_q  <= 1'b0;
         aX_q       <= '0;
         aSrcX_q    <= '0;
         aBit_q     <= '0;
         aYdst_q    <= '0;
         aYsrc_q    <= '0;
         bValid_q   <= 1'b0;
         bSrcRead_q <= 1'b0;
         bDest_q    <= '0;
         bSrc_q     <= '0;
         bBit_q     <= '0;
      end else begin
         aValid_q   <= aValid_d;
         aInside_q  <= aInside_d;
         aX_q       <= aX_d;
         aSrcX_q    <= aSrcX_d;
         aBit_q     <= aBit_d;
         aYdst_q    <= aYdst_d;
         aYsrc_q    <= aYsrc_d;
         bValid_q   <= bValid_d;
         bSrcRead_q <= bSrcRead_d;
         bDest_q    <= bDest_d;
         bSrc_q     <= bSrc_d;
         bBit_q     <= bBit_d;
      end
   end

   assign p2_valid     = bValid_q;
   assign p2_src_read  = bSrcRead_q;
   assign p2_dest_addr = bDest_q;
   assign p2_src_addr  = bSrc_q;
   assign p2_bit_index = bBit_q;
   assign idle         = !aValid_q && !bValid_q;

endmodule

// File: tb/tb_blit_address_gen.sv
// Bench for blit_address_gen: directed pixel streams checked against a queue-based
// model of the address formula, clipping and ordering, plus literal spot checks.
module tb_blit_address_gen;

   localparam logic [4:0] BLIT_RECT = 5'd1;
   localparam logic [4:0] BLIT_COPY = 5'd2;
   localparam logic [4:0] BLIT_TEXT = 5'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  reg_command = BLIT_RECT;
   logic [31:0] reg_dest_base = 32'h1000;
   logic [15:0] reg_dest_stride = 16'd640;
   logic [31:0] reg_src_base = 32'h8000;
   logic [15:0] reg_src_stride = 16'd320;
   logic [15:0] reg_clip_x1 = 16'd0;
   logic [15:0] reg_clip_y1 = 16'd0;
   logic [15:0] reg_clip_x2 = 16'd640;
   logic [15:0] reg_clip_y2 = 16'd480;
   logic [15:0] p1_x = '0, p1_y = '0, p1_src_x = '0, p1_src_y = '0;
   logic [2:0]  p1_bit_index = '0;
   logic        p1_valid = 1'b0;
   logic        p3_ready = 1'b1;
   logic        p2_ready;
   logic [31:0] p2_dest_addr;
   logic [31:0] p2_src_addr;
   logic        p2_src_read;
   logic [2:0]  p2_bit_index;
   logic        p2_valid;
   logic        idle;

   blit_address_gen #(.ADDR_W(32)) dut (
      .clock(clock), .reset(reset), .reg_command(reg_command),
      .reg_dest_base(reg_dest_base), .reg_dest_stride(reg_dest_stride),
      .reg_src_base(reg_src_base), .reg_src_stride(reg_src_stride),
      .reg_clip_x1(reg_clip_x1), .reg_clip_y1(reg_clip_y1),
      .reg_clip_x2(reg_clip_x2), .reg_clip_y2(reg_clip_y2),
      .p1_x(p1_x), .p1_y(p1_y), .p1_src_x(p1_src_x), .p1_src_y(p1_src_y),
      .p1_bit_index(p1_bit_index), .p1_valid(p1_valid), .p2_ready(p2_ready),
      .p3_ready(p3_ready), .p2_dest_addr(p2_dest_addr), .p2_src_addr(p2_src_addr),
      .p2_src_read(p2_src_read), .p2_bit_index(p2_bit_index), .p2_valid(p2_valid),
      .idle(idle)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] dest;
      logic [31:0] src;
      logic [2:0]  bitIdx;
      logic        rd;
   } pixel_t;

   pixel_t expQ[$];
   int     errorCount = 0;
   int     checkCount = 0;
   int     outCount = 0;

   function automatic void checkOutput(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endfunction

   // Model: every accepted in-clip pixel must leave once, in order, with these addresses.
   pixel_t prevOut;
   logic   prevStall = 1'b0;
   always @(negedge clock) begin
      if (reset) begin
         expQ.delete();
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("holdValid", {31'd0, p2_valid}, 32'd1);
            checkOutput("holdDest", p2_dest_addr, prevOut.dest);
            checkOutput("holdSrc", p2_src_addr, prevOut.src);
            checkOutput("holdBit", {29'd0, p2_bit_index}, {29'd0, prevOut.bitIdx});
            checkOutput("holdRead", {31'd0, p2_src_read}, {31'd0, prevOut.rd});
         end
         if (p2_valid && p3_ready) begin
            outCount++;
            if (expQ.size() == 0) begin
               checkOutput("spuriousOutput", {31'd0, p2_valid}, 32'd0);
            end else begin
               pixel_t e;
               e = expQ.pop_front();
               checkOutput("destAddr", p2_dest_addr, e.dest);
               checkOutput("srcAddr", p2_src_addr, e.src);
               checkOutput("bitIndex", {29'd0, p2_bit_index}, {29'd0, e.bitIdx});
               checkOutput("srcRead", {31'd0, p2_src_read}, {31'd0, e.rd});
            end
         end
         if (p1_valid && p2_ready) begin
            if (p1_x >= reg_clip_x1 && p1_x < reg_clip_x2 &&
                p1_y >= reg_clip_y1 && p1_y < reg_clip_y2) begin
               pixel_t n;
               n.dest   = reg_dest_base + 32'(p1_y) * 32'(reg_dest_stride) + 32'(p1_x);
               n.src    = reg_src_base + 32'(p1_src_y) * 32'(reg_src_stride) + 32'(p1_src_x);
               n.bitIdx = p1_bit_index;
               n.rd     = (reg_command == BLIT_COPY) || (reg_command == BLIT_TEXT);
               expQ.push_back(n);
            end
         end
         prevStall      = p2_valid && !p3_ready;
         prevOut.dest   = p2_dest_addr;
         prevOut.src    = p2_src_addr;
         prevOut.bitIdx = p2_bit_index;
         prevOut.rd     = p2_src_read;
      end
   end

   // Offers one pixel and returns 1ns after the clock edge that accepted it.
   task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] sx, input logic [15:0] sy,
                                input logic [2:0] b);
      int  n = 0;
      bit  ok = 0;
      p1_x = x; p1_y = y; p1_src_x = sx; p1_src_y = sy; p1_bit_index = b;
      p1_valid = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clock);
         ok = p2_ready;
         @(posedge clock);
         #1;
         n++;
      end
      if (!ok) checkOutput("acceptTimeout", 32'd0, 32'd1);
      p1_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (n < 50 && !(idle && expQ.size() == 0)) begin
         @(posedge clock);
         #1;
         n++;
      end
      checkOutput("drainIdle", {31'd0, idle}, 32'd1);
      checkOutput("drainQueueEmpty", expQ.size(), 32'd0);
   endtask

   int savedOut;

   initial begin
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rstValid", {31'd0, p2_valid}, 32'd0);
      checkOutput("rstIdle", {31'd0, idle}, 32'd1);
      checkOutput("rstReady", {31'd0, p2_ready}, 32'd1);
      checkOutput("rstDest", p2_dest_addr, 32'd0);
      checkOutput("rstSrcRead", {31'd0, p2_src_read}, 32'd0);
      reset = 1'b0;

      applyStimulus(16'd3, 16'd2, 16'd0, 16'd0, 3'd0);
      applyStimulus(16'd4, 16'd2, 16'd0, 16'd0, 3'd0);
      checkOutput("rectFirstValid", {31'd0, p2_valid}, 32'd1);
      checkOutput("rectFirstDest", p2_dest_addr, 32'h1503);
      checkOutput("rectSrcRead", {31'd0, p2_src_read}, 32'd0);
      @(posedge clock);
      #1;
      checkOutput("rectSecondDest", p2_dest_addr, 32'h1504);
      drain();

      reg_command = BLIT_COPY;
      applyStimulus(16'd5, 16'd3, 16'd10, 16'd1, 3'd0);
      @(posedge clock);
      #1;
      checkOutput("copyValid", {31'd0, p2_valid}, 32'd1);
      checkOutput("copySrc", p2_src_addr, 32'h814A);
      checkOutput("copyDest", p2_dest_addr, 32'h1785);
      checkOutput("copySrcRead", {31'd0, p2_src_read}, 32'd1);
      drain();

      reg_command = BLIT_TEXT;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'(10 + i), 16'd0, 16'd2, 16'd4, 3'(i));
         if (i == 1) begin
            checkOutput("textSrc", p2_src_addr, 32'h8502);
            checkOutput("textBit0", {29'd0, p2_bit_index}, 32'd0);
         end
      end
      drain();

      reg_command = BLIT_RECT;
      reg_clip_x1 = 16'd5;
      reg_clip_x2 = 16'd8;
      savedOut = outCount;
      for (int x = 4; x <= 8; x++) applyStimulus(16'(x), 16'd0, 16'd0, 16'd0, 3'd0);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("clipCount", outCount - savedOut, 32'd3);
      checkOutput("clipIdle", {31'd0, idle}, 32'd1);

      reg_clip_x1 = 16'd8;
      savedOut = outCount;
      for (int x = 6; x <= 8; x++) applyStimulus(16'(x), 16'd1, 16'd0, 16'd0, 3'd0);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("emptyClipCount", outCount - savedOut, 32'd0);
      checkOutput("emptyClipIdle", {31'd0, idle}, 32'd1);
      reg_clip_x1 = 16'd0;
      reg_clip_x2 = 16'd640;

      p3_ready = 1'b0;
      applyStimulus(16'd20, 16'd5, 16'd0, 16'd0, 3'd1);
      applyStimulus(16'd21, 16'd5, 16'd0, 16'd0, 3'd2);
      checkOutput("stallReadyLow", {31'd0, p2_ready}, 32'd0);
      checkOutput("stallValid", {31'd0, p2_valid}, 32'd1);
      fork
         for (int i = 0; i < 4; i++) applyStimulus(16'(22 + i), 16'd5, 16'd0, 16'd0, 3'(i));
         begin
            repeat (3) @(posedge clock);
            #1;
            p3_ready = 1'b1;
         end
      join
      drain();

      p3_ready = 1'b0;
      applyStimulus(16'd30, 16'd6, 16'd0, 16'd0, 3'd0);
      applyStimulus(16'd31, 16'd6, 16'd0, 16'd0, 3'd0);
      checkOutput("fullBeforeReset", {31'd0, p2_valid}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midRstValid", {31'd0, p2_valid}, 32'd0);
      checkOutput("midRstIdle", {31'd0, idle}, 32'd1);
      checkOutput("midRstReady", {31'd0, p2_ready}, 32'd1);
      reset = 1'b0;
      p3_ready = 1'b1;
      applyStimulus(16'd7, 16'd1, 16'd0, 16'd0, 3'd0);
      @(posedge clock);
      #1;
      checkOutput("postRstValid", {31'd0, p2_valid}, 32'd1);
      checkOutput("postRstDest", p2_dest_addr, 32'h1287);
      drain();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/blit_address_gen.md
Name: blit_address_gen

Overview:
- Pipeline stage 2 of the blitter. Consumes pixel coordinates from the coordinate generator (stage 1) and produces byte addresses for the pixel-write stage (stage 3).
- Computes destination address = dest_base + y*dest_stride + x and source address = src_base + src_y*src_stride + src_x.
- Discards pixels outside the clip rectangle.
- Has two internal register stages: A (multiply) and B (add/clip). Backpressure uses a valid/ready handshake.

Parameters:
ADDR_W, 32, width of byte addresses (8bpp, one byte per pixel)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
reg_command  in  5  active command (BLIT_RECT/BLIT_COPY/BLIT_TEXT from blit.vh); stable while blit busy
reg_dest_base  in  ADDR_W  destination bitmap base byte address
reg_dest_stride  in  16  destination bytes per row
reg_src_base  in  ADDR_W  source bitmap / font base byte address
reg_src_stride  in  16  source bytes per row
reg_clip_x1  in  16  inclusive clip left
reg_clip_y1  in  16  inclusive clip top
reg_clip_x2  in  16  exclusive clip right
reg_clip_y2  in  16  exclusive clip bottom
p1_x, p1_y  in  16 each  destination pixel coordinate
p1_src_x, p1_src_y  in  16 each  source coordinate (text: byte column, glyph row)
p1_bit_index  in  3  font bit within source byte
p1_valid  in  1  stage-1 output valid
p2_ready  out  1  stage 2 accepts p1_* this cycle
p3_ready  in  1  stage 3 accepts p2_* this cycle
p2_dest_addr  out  ADDR_W  destination byte address
p2_src_addr  out  ADDR_W  source byte address (meaningful for COPY/TEXT)
p2_src_read  out  1  stage 3 must fetch p2_src_addr (1 for COPY and TEXT, 0 for RECT)
p2_bit_index  out  3  forwarded p1_bit_index
p2_valid  out  1  p2_* outputs hold a pixel
idle  out  1  both internal stages empty; ORed into blit busy by the register block

Behaviour:
- Transfer rules:
  - Input transfer when p1_valid && p2_ready.
  - Output transfer when p2_valid && p3_ready.
- Stall logic:
  - b_adv = !b_valid || p3_ready.
  - a_adv = !a_valid || b_adv.
  - p2_ready = a_adv (combinational from registered valids and p3_ready; no path from p1_valid).
- Stage A, loads on a_adv:
  - a_valid <= p1_valid.
  - Registers x, src_x, bit_index.
  - Registers ydst = p1_y*reg_dest_stride and ysrc = p1_src_y*reg_src_stride. Both are 16x16 unsigned products, 32 bits, zero-extended or truncated to ADDR_W.
  - Registers clip flag: inside = x>=clip_x1 && x<clip_x2 && y>=clip_y1 && y<clip_y2 (unsigned compares).
- Stage B, loads on b_adv:
  - b_valid <= a_valid && inside.
  - p2_dest_addr = reg_dest_base + ydst + x.
  - p2_src_addr = reg_src_base + ysrc + src_x.
  - Additions are modulo 2^ADDR_W; wrap is silent.
- p2_valid = b_valid. p2_src_read = (reg_command==BLIT_COPY || reg_command==BLIT_TEXT), registered with stage B.
- Latency: 2 cycles from input transfer to p2_valid, absent stalls. Throughput is 1 pixel/clock.
- Clipped pixels consume a stage-A slot but never reach p2_valid.
- Holds: while p3_ready=0 and p2_valid=1, all p2_* hold unchanged. A bubble in B lets A advance even when p3_ready=0.
- idle = !a_valid && !b_valid.
- Empty clip (clip_x1>=clip_x2 or clip_y1>=clip_y2): every pixel is discarded; no p2_valid.
- Reset (any cycle, including mid-operation): a_valid=0, b_valid=0, p2_valid=0, p2_src_read=0, p2_dest_addr=0, p2_src_addr=0, p2_bit_index=0. Consequently p2_ready=1 and idle=1. In-flight pixels are dropped.
- Simultaneous input and output transfer in the same cycle is allowed; no pixel is lost or duplicated.

Test Plan:
- RECT, dest_base=0x1000, stride=640, clip 0,0..640,480, pixels (3,2),(4,2) with p3_ready=1 -> p2_dest_addr 0x1503,0x1504 two cycles after each input, in order; p2_src_read=0.
- COPY, src_base=0x8000, src_stride=320, src (10,1) -> p2_src_addr=0x814A, p2_src_read=1, dest address per formula.
- TEXT, bit_index sweeps 0..7 with src_x constant -> 8 outputs with the same p2_src_addr, p2_bit_index 0..7 in order.
- Clip x1=5,x2=8: pixels x=4..8 on row 0 -> exactly 3 outputs (x=5,6,7); idle returns to 1 after the last one.
- Backpressure: hold p3_ready=0 for 5 cycles with a continuous stream -> p2_ready drops after 2 accepted pixels; outputs stay stable; on release all pixels appear in order with no duplicates.
- Reset asserted with both stages full -> next cycle p2_valid=0, idle=1, p2_ready=1; a new pixel then completes with 2-cycle latency.
